la_checkbits_monitor: RTL and testbench
=======================================

Name: la_checkbits_monitor

Overview:
Synthesizable monitor that consumes the 16-bit checkbits status word driven by management firmware on la_output[31:16]. It tracks firmware self-test progress through an ordered list of test phases and reports pass, fail or timeout with sticky status flags. It sits directly downstream of mgmt_core_wrapper's la_output bus and replaces free-running bench monitors in on-chip or FPGA bring-up builds.

Parameters:
NUM_PHASES, 4, number of ordered test phases, legal range 1..8.
PHASE_NIBBLES, 32'h0000_5124, phase i code nibble is bits[4i+3:4i]. Default order: phase 0=4, 1=2, 2=1, 3=5.
STABLE_CYCLES, 2, consecutive identical samples required to accept a code, legal range 1..15.
TIMEOUT_CYCLES, 400000, cycles allowed from enable to done before a timeout is declared.

Ports:
core_clk  input  1  system clock
core_rst  input  1  synchronous reset, active-high
enable  input  1  1 = monitor active
clear  input  1  synchronous soft clear; same effect as core_rst
checkbits  input  16  status word from la_output[31:16]
busy  output  1  FSM is in RUN or waiting for the first start code
phase  output  3  index of the current or expected phase
pass_mask  output  NUM_PHASES  bit i set once phase i passes
done  output  1  terminal state reached (sticky)
pass  output  1  all phases passed (sticky)
fail  output  1  fail, protocol error or timeout (sticky)
timeout  output  1  fail was caused by timeout (sticky)
fail_code  output  16  accepted word that caused the fail; 16'h0000 on timeout
evt_valid  output  1  one-cycle pulse for each accepted recognised code
evt_code  output  16  code that was accepted with evt_valid

Behaviour:
- Reset and clear: all outputs 0, phase=0, sampler count=0, timeout counter=0, FSM=IDLE. clear has priority over enable.
- Code classes for phase nibble P:
  - START = {8'hA0, P, 4'h0}
  - PASS = {8'hAB, P, 4'h1}
  - FAIL = {8'hAB, P, 4'h0}
  - Any other value is unrecognised and ignored, with no evt_valid.
- Sampler:
  - checkbits is registered every cycle.
  - cnt reloads to 1 when the new sample differs from the previous one. Otherwise it increments and saturates at 15.
  - A value is accepted exactly once per stable run, on the cycle cnt reaches STABLE_CYCLES.
  - Latency: if checkbits is held from edge k, the FSM outputs and evt_valid update at edge k+STABLE_CYCLES.
  - X or Z on checkbits compares as different, so the run restarts.
- enable=0: no acceptance, cnt forced to 0, timeout counter frozen, FSM state held.
- FSM states are IDLE, RUN, DONE_PASS and DONE_FAIL.
- IDLE (busy=1 while enabled):
  - Accepted START(phase 0) moves to RUN.
  - Accepted FAIL of any phase moves to DONE_FAIL.
  - START or PASS of any other phase moves to DONE_FAIL (protocol error).
- RUN(phase i):
  - Accepted PASS(i) sets pass_mask[i]. If i=NUM_PHASES-1, go to DONE_PASS; otherwise phase=i+1 and wait in RUN for START(i+1).
  - START(i) repeated, or START(i+1) after PASS(i), is accepted with evt_valid and no error.
  - FAIL of any phase, PASS(j) with j≠i, or START(j) with j∉{i, i+1 after pass} moves to DONE_FAIL.
- DONE_PASS: done=1, pass=1, busy=0.
- DONE_FAIL: done=1, fail=1, busy=0, fail_code = the offending word.
- Both DONE states are sticky until core_rst or clear. Later codes are ignored and evt_valid stays 0.
- Timeout:
  - A 32-bit counter increments each enabled cycle while not done.
  - On reaching TIMEOUT_CYCLES, go to DONE_FAIL with timeout=1 and fail_code=0.
  - If a code is accepted on the same cycle, the code is processed first; timeout applies only if the state is still not done.
- Reset mid-operation: core_rst or clear on any cycle returns everything to reset values on the next edge. The in-flight sampler run is discarded.

Test Plan:
1. Drive A040, AB41, A020, AB21, A010, AB11, A050, AB51, each held 10 cycles -> 8 evt_valid pulses, pass_mask=4'hF, pass=1, done=1, fail=0.
2. Drive A040, AB41, A020, AB20 -> fail=1, fail_code=16'hAB20, phase=1, pass_mask=4'h1; a following AB21 is ignored.
3. Drive A040 held 1 cycle (glitch), then 16'h0000 -> no evt_valid and still IDLE. Then A040 held 2 cycles -> RUN, accepted exactly 2 edges after the value is first sampled.
4. Drive A040, then A010 with no AB41 -> protocol-error fail, fail_code=16'hA010.
5. Set TIMEOUT_CYCLES=100 and drive A040, then hold it -> fail=1 and timeout=1 at cycle 100. Toggling enable low for 20 cycles delays the timeout by exactly 20 cycles.
6. Drive A040, AB41, then assert clear for 1 cycle -> all outputs 0, phase=0. Then a full sequence as in scenario 1 -> pass=1.

Source files
------------

// File: rtl/la_checkbits_monitor.sv
// Monitors the firmware checkbits word (la_output[31:16]), debounces it and
// tracks the ordered self-test phases to a sticky pass / fail / timeout verdict.
module la_checkbits_monitor #(
    parameter int          NUM_PHASES     = 4,
    parameter logic [31:0] PHASE_NIBBLES  = 32'h0000_5124,
    parameter int          STABLE_CYCLES  = 2,
    parameter int          TIMEOUT_CYCLES = 400000
) (
    input  logic                  core_clk,
    input  logic                  core_rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [15:0]           checkbits,
    output logic                  busy,
    output logic [2:0]            phase,
    output logic [NUM_PHASES-1:0] pass_mask,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [15:0]           fail_code,
    output logic                  evt_valid,
    output logic [15:0]           evt_code
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE_PASS, S_DONE_FAIL} state_t;
    typedef enum logic [1:0] {K_NONE, K_START, K_PASS, K_FAIL} kind_t;
    typedef struct packed {
        logic       hit;
        kind_t      kind;
        logic [2:0] idx;
    } dec_t;

    localparam logic [3:0]  STABLE_Q  = 4'(STABLE_CYCLES);
    localparam logic [2:0]  LAST_PH   = 3'(NUM_PHASES - 1);
    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

    // Lowest-numbered phase wins if the nibble table contains duplicates.
    function automatic dec_t decode(input logic [15:0] w);
        dec_t d;
        d = '{hit: 1'b0, kind: K_NONE, idx: 3'd0};
        if (w[15:8] == 8'hA0 && w[3:0] == 4'h0)      d.kind = K_START;
        else if (w[15:8] == 8'hAB && w[3:0] == 4'h1) d.kind = K_PASS;
        else if (w[15:8] == 8'hAB && w[3:0] == 4'h0) d.kind = K_FAIL;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (PHASE_NIBBLES[4*i +: 4] == w[7:4]) begin
                d.hit = (d.kind != K_NONE);
                d.idx = 3'(i);
            end
        end
        return d;
    endfunction

    logic [15:0]           smp_q;
    logic [3:0]            cnt_q, cnt_d;
    logic                  stale_q, stale_d;
    logic                  accept;
    logic [31:0]           tmo_q, tmo_d;
    logic                  tmo_hit;
    state_t                state_q, state_d;
    logic [2:0]            phase_q, phase_d;
    logic                  await_q, await_d;
    logic [NUM_PHASES-1:0] mask_q, mask_d;
    logic [15:0]           fcode_q, fcode_d;
    logic                  tmo_flag_q, tmo_flag_d;
    logic                  evt_v_q, evt_v_d;
    logic [15:0]           evt_code_q, evt_code_d;
    logic                  busy_q, busy_d;
    logic                  done_now;
    logic                  bad;
    dec_t                  dec;

    assign done_now = (state_q == S_DONE_PASS) || (state_q == S_DONE_FAIL);
    // stale_q blocks a second acceptance while cnt sits saturated at STABLE_CYCLES
    assign accept   = enable && (cnt_q == STABLE_Q) && !stale_q;

    always_comb begin
        cnt_d   = cnt_q;
        stale_d = stale_q | accept;
        if (!enable) begin
            cnt_d   = 4'd0;
            stale_d = 1'b0;
        end else if (checkbits !== smp_q) begin
            cnt_d   = 4'd1;
            stale_d = 1'b0;
        end else if (cnt_q != 4'd15) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_comb begin
        tmo_d = tmo_q;
        if (enable && !done_now) tmo_d = tmo_q + 32'd1;
        tmo_hit = enable && !done_now && (tmo_d >= TMO_LIMIT);
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        await_d    = await_q;
        mask_d     = mask_q;
        fcode_d    = fcode_q;
        tmo_flag_d = tmo_flag_q;
        evt_v_d    = 1'b0;
        evt_code_d = evt_code_q;
        bad        = 1'b0;
        dec        = decode(smp_q);
        if (accept && !done_now && dec.hit) begin
            evt_v_d    = 1'b1;
            evt_code_d = smp_q;
            case (state_q)
                S_IDLE: begin
                    if (dec.kind == K_START && dec.idx == 3'd0) state_d = S_RUN;
                    else bad = 1'b1;
                end
                S_RUN: begin
                    if (dec.kind == K_FAIL) begin
                        bad = 1'b1;
                    end else if (!await_q) begin
                        if (dec.kind == K_PASS && dec.idx == phase_q) begin
                            mask_d = mask_q | (NUM_PHASES'(1) << phase_q);
                            if (phase_q == LAST_PH) begin
                                state_d = S_DONE_PASS;
                            end else begin
                                phase_d = phase_q + 3'd1;
                                await_d = 1'b1;
                            end
                        end else if (!(dec.kind == K_START && dec.idx == phase_q)) begin
                            bad = 1'b1;
                        end
                    end else begin
                        // Between PASS(i-1) and START(i): a late repeat of START(i-1) is tolerated.
                        if (dec.kind == K_START && dec.idx == phase_q) await_d = 1'b0;
                        else if (!(dec.kind == K_START && dec.idx == phase_q - 3'd1)) bad = 1'b1;
                    end
                end
                default: ;
            endcase
            if (bad) begin
                state_d = S_DONE_FAIL;
                fcode_d = smp_q;
            end
        end
        if (tmo_hit && (state_d == S_IDLE || state_d == S_RUN)) begin
            state_d    = S_DONE_FAIL;
            tmo_flag_d = 1'b1;
            fcode_d    = 16'h0000;
        end
        busy_d = (state_d == S_RUN) || (state_d == S_IDLE && enable);
    end

    always_ff @(posedge core_clk) begin
        smp_q <= checkbits;
        if (core_rst || clear) begin
            cnt_q      <= 4'd0;
            stale_q    <= 1'b0;
            tmo_q      <= 32'd0;
            state_q    <= S_IDLE;
            phase_q    <= 3'd0;
            await_q    <= 1'b0;
            mask_q     <= '0;
            fcode_q    <= 16'h0000;
            tmo_flag_q <= 1'b0;
            evt_v_q    <= 1'b0;
            evt_code_q <= 16'h0000;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            stale_q    <= stale_d;
            tmo_q      <= tmo_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            await_q    <= await_d;
            mask_q     <= mask_d;
            fcode_q    <= fcode_d;
            tmo_flag_q <= tmo_flag_d;
            evt_v_q    <= evt_v_d;
            evt_code_q <= evt_code_d;
            busy_q     <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign phase     = phase_q;
    assign pass_mask = mask_q;
    assign done      = done_now;
    assign pass      = (state_q == S_DONE_PASS);
    assign fail      = (state_q == S_DONE_FAIL);
    assign timeout   = tmo_flag_q;
    assign fail_code = fcode_q;
    assign evt_valid = evt_v_q;
    assign evt_code  = evt_code_q;

endmodule

// File: tb/tb_la_checkbits_monitor.sv
// Bench for la_checkbits_monitor: protocol-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized episodes.
module tb_la_checkbits_monitor;

    localparam int          N    = 4;
    localparam logic [31:0] NIB  = 32'h0000_5124;
    localparam int          STB  = 2;
    localparam int          TMO  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1, clr = 1'b0, en = 1'b0;
    logic [15:0] cb = 16'h0000;
    logic        d_busy, d_done, d_pass, d_fail, d_tmo, d_evt;
    logic [2:0]  d_phase;
    logic [N-1:0] d_mask;
    logic [15:0] d_fcode, d_ecode;

    always #5 clk = ~clk;

    la_checkbits_monitor #(
        .NUM_PHASES(N), .PHASE_NIBBLES(NIB), .STABLE_CYCLES(STB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .core_clk(clk), .core_rst(rst), .enable(en), .clear(clr), .checkbits(cb),
        .busy(d_busy), .phase(d_phase), .pass_mask(d_mask), .done(d_done),
        .pass(d_pass), .fail(d_fail), .timeout(d_tmo), .fail_code(d_fcode),
        .evt_valid(d_evt), .evt_code(d_ecode)
    );

    int n_vec = 0, n_bad = 0, evt_seen = 0;

    // Model: m_s counts protocol steps in the flat list START0,PASS0,START1,PASS1,...
    int          m_s, m_run, m_tcnt;
    logic [15:0] m_last, m_fcode, m_ecode;
    bit          m_done, m_pass, m_fail, m_tmo, m_busy, m_evt;

    function automatic logic [15:0] mk(int kind, int idx);
        logic [31:0] nb;
        logic [3:0]  p;
        nb = NIB >> (4 * idx);
        p  = nb[3:0];
        case (kind)
            0:       return {8'hA0, p, 4'h0};
            1:       return {8'hAB, p, 4'h1};
            default: return {8'hAB, p, 4'h0};
        endcase
    endfunction

    task automatic model_code(input logic [15:0] w);
        int kind, p, cur;
        bit bad;
        logic [31:0] nb;
        kind = -1; p = -1; bad = 0;
        if (w[15:8] == 8'hA0 && w[3:0] == 4'h0) kind = 0;
        else if (w[15:8] == 8'hAB && w[3:0] == 4'h1) kind = 1;
        else if (w[15:8] == 8'hAB && w[3:0] == 4'h0) kind = 2;
        for (int i = N - 1; i >= 0; i--) begin
            nb = NIB >> (4 * i);
            if (nb[3:0] == w[7:4]) p = i;
        end
        if (kind < 0 || p < 0) return;
        m_evt = 1; m_ecode = w;
        cur = m_s / 2;
        if (kind == 2) bad = 1;
        else if (m_s % 2 == 1) begin
            if (kind == 1 && p == cur) m_s++;
            else if (!(kind == 0 && p == cur)) bad = 1;
        end else begin
            if (kind == 0 && p == cur) m_s++;
            else if (!(kind == 0 && m_s > 0 && p == cur - 1)) bad = 1;
        end
        if (bad) begin m_done = 1; m_fail = 1; m_fcode = w; end
        else if (m_s == 2 * N) begin m_done = 1; m_pass = 1; end
    endtask

    task automatic model_step();
        bit acc;
        logic [15:0] w;
        acc = 0; w = m_last; m_evt = 0;
        if (rst || clr) begin
            m_s = 0; m_run = 0; m_tcnt = 0; m_fcode = 0; m_ecode = 0;
            m_done = 0; m_pass = 0; m_fail = 0; m_tmo = 0; m_busy = 0;
            m_last = cb;
            return;
        end
        if (en && m_run == STB) acc = 1;
        if (!en) m_run = 0;
        else if (cb !== m_last) m_run = 1;
        else m_run++;
        m_last = cb;
        if (en && !m_done) begin
            m_tcnt++;
            if (acc) model_code(w);
            if (!m_done && m_tcnt >= TMO) begin
                m_done = 1; m_fail = 1; m_tmo = 1; m_fcode = 16'h0000;
            end
        end
        m_busy = !m_done && (m_s > 0 || en);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int ph, mk_n;
        ph   = (m_s / 2 > N - 1) ? N - 1 : m_s / 2;
        mk_n = (1 << (m_s / 2)) - 1;
        chk("busy", 32'(d_busy), 32'(m_busy));
        chk("phase", 32'(d_phase), 32'(ph));
        chk("pass_mask", 32'(d_mask), 32'(mk_n));
        chk("done", 32'(d_done), 32'(m_done));
        chk("pass", 32'(d_pass), 32'(m_pass));
        chk("fail", 32'(d_fail), 32'(m_fail));
        chk("timeout", 32'(d_tmo), 32'(m_tmo));
        chk("fail_code", 32'(d_fcode), 32'(m_fcode));
        chk("evt_valid", 32'(d_evt), 32'(m_evt));
        chk("evt_code", 32'(d_ecode), 32'(m_ecode));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (d_evt === 1'b1) evt_seen++;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        step();
        rst = 1'b0;
        evt_seen = 0;
    endtask

    task automatic hold(input logic [15:0] v, input int n);
        cb = v;
        repeat (n) step();
    endtask

    task automatic full_seq();
        for (int i = 0; i < N; i++) begin
            hold(mk(0, i), 10);
            hold(mk(1, i), 10);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_busy", 32'(d_busy), 32'h0);
        chk("rst_phase", 32'(d_phase), 32'h0);
        chk("rst_done", 32'(d_done), 32'h0);
        chk("rst_fcode", 32'(d_fcode), 32'h0);
        chk("rst_evt", 32'(d_evt), 32'h0);

        // Full passing run
        en = 1'b1;
        full_seq();
        chk("s1_evts", 32'(evt_seen), 32'd8);
        chk("s1_mask", 32'(d_mask), 32'hF);
        chk("s1_pass", 32'(d_pass), 32'h1);
        chk("s1_done", 32'(d_done), 32'h1);
        chk("s1_fail", 32'(d_fail), 32'h0);

        // Explicit FAIL code in phase 1, later codes ignored
        do_reset(); en = 1'b1;
        hold(16'hA040, 10); hold(16'hAB41, 10); hold(16'hA020, 10); hold(16'hAB20, 10);
        hold(16'hAB21, 10);
        chk("s2_fail", 32'(d_fail), 32'h1);
        chk("s2_fcode", 32'(d_fcode), 32'hAB20);
        chk("s2_phase", 32'(d_phase), 32'h1);
        chk("s2_mask", 32'(d_mask), 32'h1);
        chk("s2_evts", 32'(evt_seen), 32'd4);

        // Glitch rejection and acceptance latency
        do_reset(); en = 1'b1;
        hold(16'h0000, 3); hold(16'hA040, 1); hold(16'h0000, 5);
        chk("s3_noevt", 32'(evt_seen), 32'd0);
        chk("s3_done", 32'(d_done), 32'h0);
        cb = 16'hA040;
        step(); chk("s3_lat0", 32'(d_evt), 32'h0);
        step(); chk("s3_lat1", 32'(d_evt), 32'h0);
        step(); chk("s3_lat2", 32'(d_evt), 32'h1);
        chk("s3_code", 32'(d_ecode), 32'hA040);
        hold(16'hAB41, 4);
        chk("s3_run", 32'(d_mask), 32'h1);

        // Protocol error: START of phase 2 without PASS of phase 0
        do_reset(); en = 1'b1;
        hold(16'hA040, 10); hold(16'hA010, 10);
        chk("s4_fail", 32'(d_fail), 32'h1);
        chk("s4_fcode", 32'(d_fcode), 32'hA010);
        chk("s4_tmo", 32'(d_tmo), 32'h0);

        // Timeout at exactly TMO enabled cycles
        do_reset(); en = 1'b1; cb = 16'hA040;
        repeat (TMO - 1) step();
        chk("s5_pre", 32'(d_fail), 32'h0);
        step();
        chk("s5_fail", 32'(d_fail), 32'h1);
        chk("s5_tmo", 32'(d_tmo), 32'h1);
        chk("s5_fcode", 32'(d_fcode), 32'h0);
        // Enable low for 20 cycles delays the timeout by 20
        do_reset(); en = 1'b1; cb = 16'hA040;
        repeat (30) step();
        en = 1'b0; repeat (20) step();
        en = 1'b1; repeat (TMO - 30 - 1) step();
        chk("s5b_pre", 32'(d_tmo), 32'h0);
        step();
        chk("s5b_tmo", 32'(d_tmo), 32'h1);

        // Soft clear mid-run, then a clean full run
        do_reset(); en = 1'b1;
        hold(16'hA040, 10); hold(16'hAB41, 10);
        clr = 1'b1; step(); clr = 1'b0;
        chk("s6_busy", 32'(d_busy), 32'h0);
        chk("s6_phase", 32'(d_phase), 32'h0);
        chk("s6_mask", 32'(d_mask), 32'h0);
        chk("s6_done", 32'(d_done), 32'h0);
        chk("s6_evt", 32'(d_evt), 32'h0);
        full_seq();
        chk("s6_pass", 32'(d_pass), 32'h1);

        // Randomized episodes
        for (int ep = 0; ep < 200 && n_bad < 50; ep++) begin
            rst = 1'b1; en = 1'($urandom_range(0, 1)); cb = 16'($urandom);
            step();
            rst = 1'b0;
            for (int it = 0; it < 30 && n_bad < 50; it++) begin
                int r, cur;
                logic [15:0] v;
                r = $urandom_range(0, 99);
                cur = (m_s / 2 > N - 1) ? N - 1 : m_s / 2;
                if (r < 60) v = (m_s % 2 == 1 && $urandom_range(0, 3) != 0) ? mk(1, cur) : mk(0, cur);
                else if (r < 85) v = mk($urandom_range(0, 2), $urandom_range(0, N - 1));
                else v = 16'($urandom);
                en  = ($urandom_range(0, 99) < 92);
                clr = ($urandom_range(0, 99) < 2);
                cb  = v;
                repeat ($urandom_range(1, 4)) begin
                    step();
                    clr = 1'b0;
                end
                if (m_done && $urandom_range(0, 3) == 0) break;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
